seq_comparator: RTL and testbench
=================================

# seq_comparator

- Parametrised, multi-cycle magnitude comparator; successor to the team's 2-bit combinational comparator.
- Latches two WIDTH-bit operands on a start handshake and compares them MSB-first, DIGIT bits per cycle.
- Reports the result on the same 3-bit one-hot {gt, eq, lt} code, plus a one-cycle done pulse.
- Used where wide operands make a single-cycle compare too slow, or where area is preferred over latency.

## Interface
Parameters:
- WIDTH, 8: operand width; must be a multiple of DIGIT and at least DIGIT.
- DIGIT, 2: bits compared per cycle; N = WIDTH/DIGIT slices.
- SIGNED, 0: 0 = unsigned compare; 1 = two's-complement compare.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- start, input, 1: request a compare; sampled only in IDLE.
- A, input, WIDTH: operand A; sampled on the accepting edge only.
- B, input, WIDTH: operand B; sampled on the accepting edge only.
- busy, output, 1: high while a compare is in progress.
- done, output, 1: one-cycle pulse when C is updated.
- C, output, 3: result; C[2] = A>B, C[1] = A==B, C[0] = A<B.

## Operation
- States: IDLE and RUN.
- IDLE, start=1:
  - load A and B into internal shift registers;
  - load slice counter with N;
  - busy=1; go to RUN.
- RUN, each cycle:
  - compare the top DIGIT bits of both shift registers as unsigned values;
  - shift both registers left by DIGIT;
  - decrement the counter.
- Signed mode (SIGNED=1): invert bit WIDTH-1 of both operands at load (offset-binary), then compare as unsigned.
- Resolution:
  - the first slice that differs fixes gt or lt; later slices cannot change it;
  - if no slice differs, the result is eq.
- Completion, on the edge that processes the last slice (or the deciding slice, see Configuration):
  - C is registered;
  - done=1 for one cycle, busy=0;
  - state returns to IDLE.
- C holds its value until the next completion; it is not cleared when a new compare starts.
- start while busy is ignored, not queued.
- start in the cycle done is high is accepted (state is already IDLE); back-to-back throughput is N+1 cycles per compare.
- C is always one-hot after the first completion; 3'b000 means no result since reset.

## Timing
- Reset values: busy=0, done=0, C=3'b000, state IDLE, counter 0, shift registers 0.
- Reset is asynchronous: asserting rst_n mid-RUN forces all of the above immediately.
  - The in-flight compare is discarded; no done pulse is produced.
- Accepting edge k (start=1 in IDLE): busy is high from after edge k.
- Full-length compare: slices are processed at edges k+1 … k+N.
  - done and the new C are visible after edge k+N (latency N cycles).
- Early exit (macro defined): a compare decided at slice j completes at edge k+j.
- busy and done are never high together.
- A and B may change freely after the accepting edge.

## Configuration
- Macro: SEQ_COMPARATOR_EARLY_EXIT_EN.
- Defined: RUN completes on the first differing slice (latency j cycles, 1 ≤ j ≤ N). Equal operands still take N cycles.
- Undefined: every compare takes exactly N cycles regardless of data. The result is latched internally at the deciding slice and output at slice N. Use this build for constant-time operation.
- C values are identical in both builds; only done timing differs.

## Test plan
All scenarios use WIDTH=8, DIGIT=2, N=4 unless noted.
1. Equal operands: A=8'h3C, B=8'h3C, start at edge k -> done after edge k+4, C=3'b010, busy high for 4 cycles; same timing in both builds.
2. Differ at MSB slice: A=8'h80, B=8'h7F, SIGNED=0 -> C=3'b100. With macro, done after k+1; without, after k+4.
3. Signed mode: SIGNED=1, A=8'h80 (-128), B=8'h7F -> C=3'b001. Also A=8'hFF, B=8'hFE -> C=3'b100.
4. Differ at last slice only: A=8'h12, B=8'h13 -> C=3'b001, done after k+4 in both builds.
5. Back-to-back with start held high across the done cycle, operands changed after acceptance:
   - start pulses during busy are ignored;
   - each done is exactly N+1 cycles apart (full-length build);
   - each C matches the operands present on its accepting edge.
6. Reset mid-compare: drop rst_n two cycles after acceptance.
   - busy, done and C go to 0 immediately and no done pulse appears;
   - after release, a new compare A=8'h01, B=8'h00 returns C=3'b100 with normal latency.

Source files
------------

// File: rtl/seq_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, one-hot {gt, eq, lt} result.
// Optional build macro SEQ_COMPARATOR_EARLY_EXIT_EN: complete on the first differing slice.
module seq_comparator #(
   parameter int WIDTH  = 8,
   parameter int DIGIT  = 2,
   parameter int SIGNED = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [2:0]       C
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   // Flipping the sign bit maps two's complement onto offset binary, so one unsigned compare serves both modes.
   localparam logic [WIDTH-1:0] SIGN_MASK = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [CW-1:0]    cnt;
   logic             res_dec;
   logic             res_gt;

   logic [DIGIT-1:0] top_a;
   logic [DIGIT-1:0] top_b;
   logic             slice_ne;
   logic             dec_now;
   logic             gt_now;
   logic             finish;

   assign top_a = sh_a[WIDTH-1 -: DIGIT];
   assign top_b = sh_b[WIDTH-1 -: DIGIT];

   always_comb begin
      slice_ne = (top_a != top_b);
      // Once a slice has decided, later slices are ignored.
      dec_now  = res_dec | slice_ne;
      gt_now   = res_dec ? res_gt : (top_a > top_b);
`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
      finish   = (cnt == CW'(1)) | slice_ne;
`else
      finish   = (cnt == CW'(1));
`endif
   end

   // NOTE: all state here is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sh_a    <= '0;
         sh_b    <= '0;
         cnt     <= '0;
         res_dec <= 1'b0;
         res_gt  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         C       <= 3'b000;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a    <= A ^ SIGN_MASK;
                  sh_b    <= B ^ SIGN_MASK;
                  cnt     <= CW'(N);
                  res_dec <= 1'b0;
                  res_gt  <= 1'b0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               sh_a    <= sh_a << DIGIT;
               sh_b    <= sh_b << DIGIT;
               cnt     <= cnt - CW'(1);
               res_dec <= dec_now;
               res_gt  <= gt_now;
               if (finish) begin
                  C     <= dec_now ? (gt_now ? 3'b100 : 3'b001) : 3'b010;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_comparator.sv
// Directed bench for seq_comparator: an unsigned and a signed instance share clock, reset and operands.
module tb_seq_comparator;

`ifdef SEQ_COMPARATOR_EARLY_EXIT_EN
   localparam int EE = 1;
`else
   localparam int EE = 0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       busy_u, done_u, busy_s, done_s;
   logic [2:0] c_u_sig, c_s_sig;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   seq_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(0)) dut_u (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy_u), .done(done_u), .C(c_u_sig)
   );

   seq_comparator #(.WIDTH(8), .DIGIT(2), .SIGNED(1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
      .busy(busy_s), .done(done_s), .C(c_s_sig)
   );

   function automatic logic [2:0] exp_cmp(input logic [7:0] a, input logic [7:0] b);
      return {a > b, a == b, a < b};
   endfunction

   // Launch one compare and observe both instances; latencies are counted in edges after the accepting edge.
   task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                          output int lat_u, output int lat_s,
                          output logic [2:0] c_u, output logic [2:0] c_s,
                          output int busy_cnt, output int bad);
      lat_u = -1; lat_s = -1; c_u = 3'bxxx; c_s = 3'bxxx; busy_cnt = 0; bad = 0;
      @(negedge clk); A = a; B = b; start = 1'b1;
      @(negedge clk); start = 1'b0; A = ~a; B = ~b;
      for (int s = 0; s <= 20; s++) begin
         if (done_u && lat_u < 0) begin lat_u = s; c_u = c_u_sig; end
         if (done_s && lat_s < 0) begin lat_s = s; c_s = c_s_sig; end
         if ((busy_u && done_u) || (busy_s && done_s)) bad++;
         if (lat_u < 0 && !busy_u) bad++;
         if (lat_s < 0 && !busy_s) bad++;
         if (busy_u) busy_cnt++;
         if (lat_u >= 0 && lat_s >= 0) break;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (busy_u !== 1'b0)   begin n_fail++; $display("FAIL reset_busy_u got %b want 0", busy_u); end
      n_checks++; if (done_u !== 1'b0)   begin n_fail++; $display("FAIL reset_done_u got %b want 0", done_u); end
      n_checks++; if (c_u_sig !== 3'b000) begin n_fail++; $display("FAIL reset_c_u got %b want 000", c_u_sig); end
      n_checks++; if (busy_s !== 1'b0)   begin n_fail++; $display("FAIL reset_busy_s got %b want 0", busy_s); end
      n_checks++; if (done_s !== 1'b0)   begin n_fail++; $display("FAIL reset_done_s got %b want 0", done_s); end
      n_checks++; if (c_s_sig !== 3'b000) begin n_fail++; $display("FAIL reset_c_s got %b want 000", c_s_sig); end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_equal();
      int lu, ls, bc, bad; logic [2:0] cu, cs;
      run_cmp(8'h3C, 8'h3C, lu, ls, cu, cs, bc, bad);
      n_checks++; if (lu !== 4)      begin n_fail++; $display("FAIL equal_lat_u got %0d want 4", lu); end
      n_checks++; if (cu !== 3'b010) begin n_fail++; $display("FAIL equal_c_u got %b want 010", cu); end
      n_checks++; if (bc !== 4)      begin n_fail++; $display("FAIL equal_busy_cycles got %0d want 4", bc); end
      n_checks++; if (bad !== 0)     begin n_fail++; $display("FAIL equal_busy_done got %0d want 0", bad); end
      n_checks++; if (ls !== 4)      begin n_fail++; $display("FAIL equal_lat_s got %0d want 4", ls); end
      n_checks++; if (cs !== 3'b010) begin n_fail++; $display("FAIL equal_c_s got %b want 010", cs); end
   endtask

   task automatic test_msb_slice();
      int lu, ls, bc, bad; logic [2:0] cu, cs;
      int want_lat;
      want_lat = (EE != 0) ? 1 : 4;
      run_cmp(8'h80, 8'h7F, lu, ls, cu, cs, bc, bad);
      n_checks++; if (cu !== 3'b100)   begin n_fail++; $display("FAIL msb_c_u got %b want 100", cu); end
      n_checks++; if (lu !== want_lat) begin n_fail++; $display("FAIL msb_lat_u got %0d want %0d", lu, want_lat); end
      n_checks++; if (cs !== 3'b001)   begin n_fail++; $display("FAIL msb_c_s got %b want 001", cs); end
      n_checks++; if (ls !== want_lat) begin n_fail++; $display("FAIL msb_lat_s got %0d want %0d", ls, want_lat); end
      n_checks++; if (bad !== 0)       begin n_fail++; $display("FAIL msb_busy_done got %0d want 0", bad); end
   endtask

   task automatic test_signed();
      int lu, ls, bc, bad; logic [2:0] cu, cs;
      run_cmp(8'hFF, 8'hFE, lu, ls, cu, cs, bc, bad);
      n_checks++; if (cs !== 3'b100) begin n_fail++; $display("FAIL signed_c_s got %b want 100", cs); end
      n_checks++; if (ls !== 4)      begin n_fail++; $display("FAIL signed_lat_s got %0d want 4", ls); end
      n_checks++; if (cu !== 3'b100) begin n_fail++; $display("FAIL signed_c_u got %b want 100", cu); end
      run_cmp(8'hFE, 8'h01, lu, ls, cu, cs, bc, bad);
      n_checks++; if (cs !== 3'b001) begin n_fail++; $display("FAIL signed_neg_c_s got %b want 001", cs); end
      n_checks++; if (cu !== 3'b100) begin n_fail++; $display("FAIL signed_neg_c_u got %b want 100", cu); end
   endtask

   task automatic test_last_slice();
      int lu, ls, bc, bad; logic [2:0] cu, cs;
      run_cmp(8'h12, 8'h13, lu, ls, cu, cs, bc, bad);
      n_checks++; if (cu !== 3'b001) begin n_fail++; $display("FAIL last_c_u got %b want 001", cu); end
      n_checks++; if (lu !== 4)      begin n_fail++; $display("FAIL last_lat_u got %0d want 4", lu); end
      n_checks++; if (cs !== 3'b001) begin n_fail++; $display("FAIL last_c_s got %b want 001", cs); end
      n_checks++; if (ls !== 4)      begin n_fail++; $display("FAIL last_lat_s got %0d want 4", ls); end
   endtask

   // Operands change every cycle with start held high; only pairs on accepting edges (t = 0, 5, 10) count.
   task automatic test_back_to_back();
      logic [7:0] pa [3];
      logic [7:0] pb [3];
      logic [7:0] ta [15];
      logic [7:0] tb [15];
      int n_done;
      pa[0] = 8'h12; pb[0] = 8'h13;
      pa[1] = 8'h55; pb[1] = 8'h55;
      pa[2] = 8'h27; pb[2] = 8'h26;
      for (int t = 0; t < 15; t++) begin
         if (t % 5 == 0) begin ta[t] = pa[t/5]; tb[t] = pb[t/5]; end
         else begin ta[t] = 8'hF0 ^ 8'(t); tb[t] = 8'h0F ^ 8'(t); end
      end
      n_done = 0;
      @(negedge clk); A = ta[0]; B = tb[0]; start = 1'b1;
      for (int t = 0; t < 15; t++) begin
         @(negedge clk);
         if (done_u) n_done++;
         if (t % 5 == 4) begin
            n_checks++; if (done_u !== 1'b1) begin n_fail++; $display("FAIL b2b_done_t%0d got %b want 1", t, done_u); end
            n_checks++;
            if (c_u_sig !== exp_cmp(ta[t-4], tb[t-4])) begin
               n_fail++; $display("FAIL b2b_c_t%0d got %b want %b", t, c_u_sig, exp_cmp(ta[t-4], tb[t-4]));
            end
         end else begin
            n_checks++; if (done_u !== 1'b0) begin n_fail++; $display("FAIL b2b_nodone_t%0d got %b want 0", t, done_u); end
         end
         n_checks++; if (busy_u && done_u) begin n_fail++; $display("FAIL b2b_busy_done_t%0d got 1 want 0", t); end
         if (t < 14) begin A = ta[t+1]; B = tb[t+1]; end
         else start = 1'b0;
      end
      n_checks++; if (n_done !== 3) begin n_fail++; $display("FAIL b2b_done_count got %0d want 3", n_done); end
      @(negedge clk);
      n_checks++; if (busy_u !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after got %b want 0", busy_u); end
   endtask

   task automatic test_reset_mid();
      int lu, ls, bc, bad; logic [2:0] cu, cs;
      int spurious;
      spurious = 0;
      @(negedge clk); A = 8'h3C; B = 8'h3C; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      n_checks++; if (busy_u !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy_u); end
      n_checks++; if (done_u !== 1'b0)    begin n_fail++; $display("FAIL midrst_done got %b want 0", done_u); end
      n_checks++; if (c_u_sig !== 3'b000) begin n_fail++; $display("FAIL midrst_c got %b want 000", c_u_sig); end
      n_checks++; if (c_s_sig !== 3'b000) begin n_fail++; $display("FAIL midrst_c_s got %b want 000", c_s_sig); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done_u || done_s || busy_u) spurious++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done_u || done_s || busy_u) spurious++;
      end
      n_checks++; if (spurious !== 0) begin n_fail++; $display("FAIL midrst_spurious got %0d want 0", spurious); end
      run_cmp(8'h01, 8'h00, lu, ls, cu, cs, bc, bad);
      n_checks++; if (cu !== 3'b100) begin n_fail++; $display("FAIL postrst_c_u got %b want 100", cu); end
      n_checks++; if (lu !== 4)      begin n_fail++; $display("FAIL postrst_lat_u got %0d want 4", lu); end
      n_checks++; if (cs !== 3'b100) begin n_fail++; $display("FAIL postrst_c_s got %b want 100", cs); end
   endtask

   initial begin
      test_reset();
      test_equal();
      test_msb_slice();
      test_signed();
      test_last_slice();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
